// File: rtl/pll_seq_pkg.sv
// ----------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and constants for the PLL reset sequencer.
//   pll_seq_state_t : sequencer FSM states
//   LOSS_CNT_W      : width of the lock-loss event counter
//   SYNC_STAGES     : flop count of the locked-input synchronizer
//   sat_inc()       : saturating increment for the loss counter
// ----------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int LOSS_CNT_W  = 8;
    localparam int SYNC_STAGES = 2;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        logic [LOSS_CNT_W-1:0] r;
        if (v == {LOSS_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + LOSS_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// ----------------------------------------------------------------------------
// bit_sync
// N-flop synchronizer for a single asynchronous level, with synchronous reset
// clearing every stage to 0.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input level
//   q   : synchronized output (last stage)
// ----------------------------------------------------------------------------
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift chain; stage 0 is the only flop that samples the async input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
// Drives a PLL's reset and watches its locked output from the free-running
// reference clock. System reset is released only after lock has been stable
// for LOCK_STABLE_CYCLES; a loss of lock while running re-asserts system
// reset, re-resets the PLL and is counted.
//
// Build option: macro PLL_RETRY_EN
//   defined   -> a lock timeout re-resets the PLL and tries again forever
//   undefined -> a lock timeout parks in FAIL until rst
//
// Ports:
//   refclk      : reference clock (sole clock)
//   rst         : synchronous active-high reset
//   locked      : PLL lock, asynchronous to refclk
//   pll_rst     : reset to the PLL, active-high
//   sys_rst     : downstream synchronous reset, active-high
//   ready       : high only while running with lock
//   loss_count  : lock-loss events seen while running, saturating at 255
//   timeout_err : sticky lock-timeout flag
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic       timeout_err
);

    import pll_seq_pkg::*;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic           locked_s;
    pll_seq_state_t state_r;
    pll_seq_state_t state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic           timeout_hit_s;
    logic           loss_hit_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // Next-state decode plus the one-cycle event strobes it implies.
    always_comb begin
        state_nxt_s   = state_r;
        timeout_hit_s = 1'b0;
        loss_hit_s    = 1'b0;
        case (state_r)
            ST_RESET_PLL: begin
                if (cnt_r == RST_LAST) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else begin
                    state_nxt_s = ST_RESET_PLL;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt_s = ST_STABLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    timeout_hit_s = 1'b1;
`ifdef PLL_RETRY_EN
                    state_nxt_s = ST_RESET_PLL;
`else
                    state_nxt_s = ST_FAIL;
`endif
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                // A lock drop beats a coincident window completion.
                if (!locked_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    loss_hit_s  = 1'b1;
                    state_nxt_s = ST_RESET_PLL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FAIL: begin
                state_nxt_s = ST_FAIL;
            end
            default: begin
                state_nxt_s = ST_RESET_PLL;
            end
        endcase
    end

    // State register and shared cycle counter, cleared on every state entry.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r <= ST_RESET_PLL;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Outputs decoded from the next state so they move with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            pll_rst <= (state_nxt_s == ST_RESET_PLL);
            sys_rst <= (state_nxt_s != ST_RUN);
            ready   <= (state_nxt_s == ST_RUN);
        end
    end

    // Saturating loss counter and sticky timeout flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_count  <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (loss_hit_s) begin
                loss_count <= sat_inc(loss_count);
            end
            if (timeout_hit_s) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Self-checking bench for pll_reset_sequencer with small timing parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so a sample taken after n ticks shows the result of edge n.
// Expected timings come from arithmetic on the parameters (synchronizer
// latency, pulse, window and timeout lengths) rather than an FSM copy.
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int RP = 4;    // reset pulse cycles
    localparam int LS = 8;    // lock stable cycles
    localparam int LT = 32;   // lock timeout cycles
    localparam int SYNC_LAT = 2;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] loss_count;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int exp_loss = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (LT),
        .CNT_W               (17)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .loss_count  (loss_count),
        .timeout_err (timeout_err)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (plain arithmetic) ----------------
    // locked change -> sequencer reacts: synchronizer stages plus state edge
    function automatic int react_delay();
        return SYNC_LAT + 1;
    endfunction
    // locked rise while waiting -> release
    function automatic int release_delay();
        return react_delay() + LS;
    endfunction
    // rst release with locked already high -> release
    function automatic int cold_release_delay();
        return RP + 1 + LS;
    endfunction
    function automatic int sat_add(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction
    // pll_rst expectation c ticks after rst release with locked held low
    function automatic logic exp_pll_timeout(input int c);
`ifdef PLL_RETRY_EN
        return ((c % (RP + LT)) < RP);
`else
        return (c < RP);
`endif
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic cycles_until_sys(input logic val, input int limit, output int n);
        n = 0;
        while (sys_rst !== val && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        locked = 1'b0;
        tick(3);
        checks++;
        if ({pll_rst, sys_rst, ready, loss_count, timeout_err} !== {1'b1, 1'b1, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got %b want %b",
                     {pll_rst, sys_rst, ready, loss_count, timeout_err}, {1'b1, 1'b1, 1'b0, 8'd0, 1'b0});
        end
        exp_loss = 0;
    endtask

    task automatic test_power_up();
        int n;
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin
            n++;
            tick(1);
        end
        checks++;
        if (n != RP) begin
            errors++;
            $display("FAIL powerup_pll_pulse got %0d want %0d", n, RP);
        end
        tick(10 - n);
        locked = 1'b1;
        cycles_until_sys(1'b0, 40, n);
        checks++;
        if (n != release_delay()) begin
            errors++;
            $display("FAIL powerup_release got %0d want %0d", n, release_delay());
        end
        checks++;
        if ({ready, pll_rst, loss_count} !== {1'b1, 1'b0, 8'(exp_loss)}) begin
            errors++;
            $display("FAIL powerup_run_outputs got %b want %b", {ready, pll_rst, loss_count}, {1'b1, 1'b0, 8'(exp_loss)});
        end
    endtask

    task automatic test_glitch_stable();
        int n;
        int k;
        int g;
        logic early;
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1;
            locked = 1'b0;
            tick(1);
            rst = 1'b0;
            exp_loss = 0;
            tick(RP + $urandom_range(0, 6));
            locked = 1'b1;
            // first pass lands the drop on the window's final cycle
            k = (i == 0) ? LS : $urandom_range(2, LS);
            g = (i == 0) ? 3 : $urandom_range(1, 3);
            early = 1'b0;
            for (int c = 0; c < k; c++) begin
                tick(1);
                if (sys_rst !== 1'b1) early = 1'b1;
            end
            locked = 1'b0;
            for (int c = 0; c < g; c++) begin
                tick(1);
                if (sys_rst !== 1'b1) early = 1'b1;
            end
            locked = 1'b1;
            checks++;
            if (early !== 1'b0) begin
                errors++;
                $display("FAIL glitch_sys_rst_held got %b want 0 (k=%0d g=%0d)", early, k, g);
            end
            cycles_until_sys(1'b0, 40, n);
            checks++;
            if (n != release_delay()) begin
                errors++;
                $display("FAIL glitch_window_restart got %0d want %0d (k=%0d g=%0d)", n, release_delay(), k, g);
            end
        end
    endtask

    task automatic test_loss_run();
        int n;
        int m;
        tick($urandom_range(1, 20));
        locked = 1'b0;
        cycles_until_sys(1'b1, 40, n);
        exp_loss = sat_add(exp_loss);
        checks++;
        if (n != react_delay()) begin
            errors++;
            $display("FAIL loss_latency got %0d want %0d", n, react_delay());
        end
        checks++;
        if ({pll_rst, ready, loss_count} !== {1'b1, 1'b0, 8'(exp_loss)}) begin
            errors++;
            $display("FAIL loss_outputs got %b want %b", {pll_rst, ready, loss_count}, {1'b1, 1'b0, 8'(exp_loss)});
        end
        m = 0;
        while (pll_rst === 1'b1 && m < 50) begin
            m++;
            tick(1);
        end
        checks++;
        if (m != RP) begin
            errors++;
            $display("FAIL loss_pll_pulse got %0d want %0d", m, RP);
        end
        tick($urandom_range(0, 10));
        locked = 1'b1;
        cycles_until_sys(1'b0, 40, n);
        checks++;
        if (n != release_delay() || ready !== 1'b1) begin
            errors++;
            $display("FAIL loss_relock got %0d/%b want %0d/1", n, ready, release_delay());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            locked = 1'b0;
            tick(react_delay());
            exp_loss = sat_add(exp_loss);
            checks++;
            if (loss_count !== 8'(exp_loss)) begin
                errors++;
                $display("FAIL sat_loss_count got %0d want %0d (event %0d)", loss_count, exp_loss, i);
            end
            tick(RP + $urandom_range(0, 4));
            locked = 1'b1;
            tick(release_delay() + $urandom_range(0, 3));
        end
        checks++;
        if (loss_count !== 8'd255 || ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_final got %0d/%b want 255/1", loss_count, ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        tick($urandom_range(1, 10));
        rst = 1'b1;
        tick(1);
        exp_loss = 0;
        checks++;
        if ({pll_rst, sys_rst, ready, loss_count, timeout_err} !== {1'b1, 1'b1, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL midrun_reset got %b want %b",
                     {pll_rst, sys_rst, ready, loss_count, timeout_err}, {1'b1, 1'b1, 1'b0, 8'd0, 1'b0});
        end
        rst = 1'b0;
        cycles_until_sys(1'b0, 60, n);
        checks++;
        if (n != cold_release_delay()) begin
            errors++;
            $display("FAIL midrun_rerelease got %0d want %0d", n, cold_release_delay());
        end
    endtask

    task automatic test_timeout();
        int bad_pll;
        int bad_sys;
        int bad_err;
        int n;
        logic exp_err;
        rst = 1'b1;
        locked = 1'b0;
        tick(2);
        rst = 1'b0;
        bad_pll = 0;
        bad_sys = 0;
        bad_err = 0;
        for (int c = 0; c <= 2 * (RP + LT) + 8; c++) begin
`ifndef PLL_RETRY_EN
            if (c == RP + LT + 9) locked = 1'b1;   // lock arriving in FAIL must be ignored
`endif
            exp_err = (c >= RP + LT);
            if (pll_rst !== exp_pll_timeout(c)) bad_pll++;
            if (sys_rst !== 1'b1) bad_sys++;
            if (timeout_err !== exp_err) bad_err++;
            tick(1);
        end
        checks++;
        if (bad_pll != 0) begin
            errors++;
            $display("FAIL timeout_pll_rst got %0d bad samples want 0", bad_pll);
        end
        checks++;
        if (bad_sys != 0) begin
            errors++;
            $display("FAIL timeout_sys_rst got %0d bad samples want 0", bad_sys);
        end
        checks++;
        if (bad_err != 0) begin
            errors++;
            $display("FAIL timeout_err_flag got %0d bad samples want 0", bad_err);
        end
        rst = 1'b1;
        locked = 1'b1;
        tick(1);
        checks++;
        if (timeout_err !== 1'b0 || pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover_reset got %b%b want 01", timeout_err, pll_rst);
        end
        rst = 1'b0;
        cycles_until_sys(1'b0, 60, n);
        checks++;
        if (n != cold_release_delay() || ready !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover_run got %0d/%b/%b want %0d/1/0", n, ready, timeout_err, cold_release_delay());
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_glitch_stable();
        test_loss_run();
        test_saturation();
        test_reset_mid_run();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
